// File: rtl/png_stream_ctrl.sv
// PNG chunk sequencer: emits signature, IHDR, one IDAT wrapping the zlib stream and IEND as
// 32-bit words, mirrors CRC-covered words to the shared CRC-32 engine and splices its result back in.
module png_stream_ctrl #(
    parameter int DATA_WD     = 32,
    parameter int NUM_WD      = 2,
    parameter int SIZE_PIC_WD = 32,
    parameter int LEN_WD      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [SIZE_PIC_WD-1:0] w_i,
    input  logic [SIZE_PIC_WD-1:0] h_i,
    input  logic [LEN_WD-1:0]      idat_len_i,
    input  logic                   zl_val_i,
    input  logic [DATA_WD-1:0]     zl_dat_i,
    input  logic [NUM_WD-1:0]      zl_num_i,
    input  logic                   zl_lst_i,
    output logic                   zl_rdy_o,
    output logic                   crc_clr_o,
    output logic                   crc_val_o,
    output logic [DATA_WD-1:0]     crc_dat_o,
    output logic [NUM_WD-1:0]      crc_num_o,
    output logic                   crc_lst_o,
    input  logic                   crc_val_i,
    input  logic [DATA_WD-1:0]     crc_dat_i,
    output logic                   val_o,
    output logic [DATA_WD-1:0]     dat_o,
    output logic [NUM_WD-1:0]      num_o,
    output logic                   lst_o,
    input  logic                   rdy_i,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [DATA_WD-1:0] SIG0_WORD = DATA_WD'(32'h89504E47);
    localparam logic [DATA_WD-1:0] SIG1_WORD = DATA_WD'(32'h0D0A1A0A);
    localparam logic [DATA_WD-1:0] IHDR_LEN_WORD = DATA_WD'(32'h0000000D);
    localparam logic [DATA_WD-1:0] IHDR_TYPE_WORD = DATA_WD'(32'h49484452);
    localparam logic [DATA_WD-1:0] IHDR_MISC_WORD = DATA_WD'(32'h08020000);
    localparam logic [DATA_WD-1:0] IDAT_TYPE_WORD = DATA_WD'(32'h49444154);
    localparam logic [DATA_WD-1:0] IEND_TYPE_WORD = DATA_WD'(32'h49454E44);
    localparam logic [DATA_WD-1:0] IEND_CRC_WORD = DATA_WD'(32'hAE426082);
    localparam logic [NUM_WD-1:0]  NUM_FULL = '1;

    typedef enum logic [4:0] {
        S_IDLE,
        S_SIG0,
        S_SIG1,
        S_IHDR_LEN,
        S_IHDR_TYPE,
        S_IHDR_W,
        S_IHDR_H,
        S_IHDR_MISC,
        S_IHDR_END,
        S_IHDR_CRC_WAIT,
        S_IHDR_CRC_OUT,
        S_IDAT_LEN,
        S_IDAT_TYPE,
        S_IDAT_DATA,
        S_IDAT_CRC_WAIT,
        S_IDAT_CRC_OUT,
        S_IEND_LEN,
        S_IEND_TYPE,
        S_IEND_CRC
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SIZE_PIC_WD-1:0] w_reg;
    logic [SIZE_PIC_WD-1:0] h_reg;
    logic [LEN_WD-1:0]      len_reg;
    logic [LEN_WD-1:0]      byte_cnt;
    logic [LEN_WD-1:0]      byte_sum;
    logic [DATA_WD-1:0]     crc_hold;
    logic                   crc_held;

    logic                   load;
    logic                   start_ok;
    logic                   zl_take;
    logic                   crc_rdy;
    logic                   in_crc_wait;
    logic                   in_crc_out;

    logic                   word_vld;
    logic [DATA_WD-1:0]     word_dat;
    logic [NUM_WD-1:0]      word_num;
    logic                   word_lst;
    logic                   word_cov;
    logic                   word_cov_lst;
    logic                   word_clr;

    assign load        = !val_o || rdy_i;
    assign start_ok    = (state == S_IDLE) && start_i;
    assign zl_take     = (state == S_IDAT_DATA) && load && zl_val_i;
    assign crc_rdy     = crc_val_i || crc_held;
    assign in_crc_wait = (state == S_IHDR_CRC_WAIT) || (state == S_IDAT_CRC_WAIT);
    assign in_crc_out  = (state == S_IHDR_CRC_OUT) || (state == S_IDAT_CRC_OUT);
    assign byte_sum    = byte_cnt + LEN_WD'(zl_num_i) + LEN_WD'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:          if (start_i) state_nxt = S_SIG0;
            S_SIG0:          if (load) state_nxt = S_SIG1;
            S_SIG1:          if (load) state_nxt = S_IHDR_LEN;
            S_IHDR_LEN:      if (load) state_nxt = S_IHDR_TYPE;
            S_IHDR_TYPE:     if (load) state_nxt = S_IHDR_W;
            S_IHDR_W:        if (load) state_nxt = S_IHDR_H;
            S_IHDR_H:        if (load) state_nxt = S_IHDR_MISC;
            S_IHDR_MISC:     if (load) state_nxt = S_IHDR_END;
            S_IHDR_END:      if (load) state_nxt = S_IHDR_CRC_WAIT;
            S_IHDR_CRC_WAIT: if (crc_rdy && load) state_nxt = S_IHDR_CRC_OUT;
            S_IHDR_CRC_OUT:  if (load) state_nxt = S_IDAT_LEN;
            S_IDAT_LEN:      if (load) state_nxt = S_IDAT_TYPE;
            S_IDAT_TYPE:     if (load) state_nxt = (len_reg == '0) ? S_IDAT_CRC_WAIT : S_IDAT_DATA;
            S_IDAT_DATA:     if (zl_take && zl_lst_i) state_nxt = S_IDAT_CRC_WAIT;
            S_IDAT_CRC_WAIT: if (crc_rdy && load) state_nxt = S_IDAT_CRC_OUT;
            S_IDAT_CRC_OUT:  if (load) state_nxt = S_IEND_LEN;
            S_IEND_LEN:      if (load) state_nxt = S_IEND_TYPE;
            S_IEND_TYPE:     if (load) state_nxt = S_IEND_CRC;
            S_IEND_CRC:      if (load) state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // The word each state offers to the output register, plus its CRC-engine side effects.
    always_comb begin
        word_vld     = 1'b0;
        word_dat     = '0;
        word_num     = NUM_FULL;
        word_lst     = 1'b0;
        word_cov     = 1'b0;
        word_cov_lst = 1'b0;
        word_clr     = 1'b0;
        zl_rdy_o     = 1'b0;
        case (state)
            S_SIG0:      begin word_vld = 1'b1; word_dat = SIG0_WORD; end
            S_SIG1:      begin word_vld = 1'b1; word_dat = SIG1_WORD; end
            S_IHDR_LEN:  begin word_vld = 1'b1; word_dat = IHDR_LEN_WORD; word_clr = 1'b1; end
            S_IHDR_TYPE: begin word_vld = 1'b1; word_dat = IHDR_TYPE_WORD; word_cov = 1'b1; end
            S_IHDR_W:    begin word_vld = 1'b1; word_dat = DATA_WD'(w_reg); word_cov = 1'b1; end
            S_IHDR_H:    begin word_vld = 1'b1; word_dat = DATA_WD'(h_reg); word_cov = 1'b1; end
            S_IHDR_MISC: begin word_vld = 1'b1; word_dat = IHDR_MISC_WORD; word_cov = 1'b1; end
            S_IHDR_END: begin
                word_vld     = 1'b1;
                word_num     = '0;
                word_cov     = 1'b1;
                word_cov_lst = 1'b1;
            end
            S_IHDR_CRC_OUT, S_IDAT_CRC_OUT: begin
                word_vld = 1'b1;
                word_dat = crc_hold;
            end
            S_IDAT_LEN:  begin word_vld = 1'b1; word_dat = DATA_WD'(len_reg); word_clr = 1'b1; end
            S_IDAT_TYPE: begin
                word_vld     = 1'b1;
                word_dat     = IDAT_TYPE_WORD;
                word_cov     = 1'b1;
                word_cov_lst = (len_reg == '0);
            end
            S_IDAT_DATA: begin
                zl_rdy_o     = load;
                word_vld     = zl_val_i;
                word_dat     = zl_dat_i;
                word_num     = zl_num_i;
                word_cov     = 1'b1;
                word_cov_lst = zl_lst_i;
            end
            S_IEND_LEN:  begin word_vld = 1'b1; end
            S_IEND_TYPE: begin word_vld = 1'b1; word_dat = IEND_TYPE_WORD; end
            S_IEND_CRC:  begin word_vld = 1'b1; word_dat = IEND_CRC_WORD; word_lst = 1'b1; end
            default: ;
        endcase
    end

    // Output register and the CRC mirror load together so the engine sees exactly the emitted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_o     <= 1'b0;
            dat_o     <= '0;
            num_o     <= '0;
            lst_o     <= 1'b0;
            crc_clr_o <= 1'b0;
            crc_val_o <= 1'b0;
            crc_dat_o <= '0;
            crc_num_o <= '0;
            crc_lst_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            crc_val_o <= load && word_vld && word_cov;
            crc_lst_o <= load && word_vld && word_cov_lst;
            crc_clr_o <= load && word_vld && word_clr;
            done_o    <= val_o && rdy_i && lst_o;
            if (load && word_vld && word_cov) begin
                crc_dat_o <= word_dat;
                crc_num_o <= word_num;
            end
            if (load) begin
                val_o <= word_vld;
                lst_o <= word_vld && word_lst;
                if (word_vld) begin
                    dat_o <= word_dat;
                    num_o <= word_num;
                end
            end
        end
    end

    // A CRC that arrives while the output is stalled is parked until CRC_OUT can emit it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_reg    <= '0;
            h_reg    <= '0;
            len_reg  <= '0;
            byte_cnt <= '0;
            err_o    <= 1'b0;
            crc_hold <= '0;
            crc_held <= 1'b0;
        end else begin
            if (start_ok) begin
                w_reg    <= w_i;
                h_reg    <= h_i;
                len_reg  <= idat_len_i;
                byte_cnt <= '0;
                err_o    <= 1'b0;
            end
            if (zl_take) begin
                byte_cnt <= byte_sum;
                if (zl_lst_i && (byte_sum != len_reg)) err_o <= 1'b1;
            end
            if (in_crc_wait && crc_val_i) begin
                crc_hold <= crc_dat_i;
                crc_held <= 1'b1;
            end else if (in_crc_out && load) begin
                crc_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_png_stream_ctrl.sv
// Scoreboard bench for png_stream_ctrl: a reference model queues the expected PNG words and a
// monitor pops them on every output transfer; a behavioural CRC-32 engine answers the DUT.
module tb_png_stream_ctrl;

    localparam int TIMEOUT = 3000;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  num;
        logic        lst;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] w_i;
    logic [31:0] h_i;
    logic [31:0] idat_len_i;
    logic        zl_val_i;
    logic [31:0] zl_dat_i;
    logic [1:0]  zl_num_i;
    logic        zl_lst_i;
    logic        zl_rdy_o;
    logic        crc_clr_o;
    logic        crc_val_o;
    logic [31:0] crc_dat_o;
    logic [1:0]  crc_num_o;
    logic        crc_lst_o;
    logic        crc_val_i;
    logic [31:0] crc_dat_i;
    logic        val_o;
    logic [31:0] dat_o;
    logic [1:0]  num_o;
    logic        lst_o;
    logic        rdy_i;
    logic        done_o;
    logic        err_o;

    int tests_run = 0;
    int tests_failed = 0;

    word_t       exp_q[$];
    word_t       stim_q[$];
    word_t       zl_q[$];
    logic [7:0]  model_bytes[$];
    bit          rand_rdy;
    bit          rand_zl;
    bit          feed_en;
    int          done_cnt;
    int          clr_cnt;
    logic [31:0] cur_len;
    int          crc_latency;

    png_stream_ctrl #(
        .DATA_WD(32), .NUM_WD(2), .SIZE_PIC_WD(32), .LEN_WD(32)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .w_i(w_i), .h_i(h_i), .idat_len_i(idat_len_i),
        .zl_val_i(zl_val_i), .zl_dat_i(zl_dat_i), .zl_num_i(zl_num_i), .zl_lst_i(zl_lst_i),
        .zl_rdy_o(zl_rdy_o), .crc_clr_o(crc_clr_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
        .crc_num_o(crc_num_o), .crc_lst_o(crc_lst_o), .crc_val_i(crc_val_i), .crc_dat_i(crc_dat_i),
        .val_o(val_o), .dat_o(dat_o), .num_o(num_o), .lst_o(lst_o), .rdy_i(rdy_i),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crcOfModel();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (model_bytes[k]) c = crc_step(c, model_bytes[k]);
        return ~c;
    endfunction

    task automatic addBytes(input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) model_bytes.push_back(d[31-8*k -: 8]);
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [1:0] n, input logic l);
        word_t t;
        t.dat = d;
        t.num = n;
        t.lst = l;
        exp_q.push_back(t);
    endtask

    // Reference model: the whole PNG file as a word list, CRCs computed from the chunk bytes.
    task automatic buildExpected(input logic [31:0] w, input logic [31:0] h, input logic [31:0] len);
        pushExp(32'h89504E47, 2'd3, 1'b0);
        pushExp(32'h0D0A1A0A, 2'd3, 1'b0);
        pushExp(32'h0000000D, 2'd3, 1'b0);
        pushExp(32'h49484452, 2'd3, 1'b0);
        pushExp(w, 2'd3, 1'b0);
        pushExp(h, 2'd3, 1'b0);
        pushExp(32'h08020000, 2'd3, 1'b0);
        pushExp(32'h00000000, 2'd0, 1'b0);
        model_bytes.delete();
        addBytes(32'h49484452, 4);
        addBytes(w, 4);
        addBytes(h, 4);
        addBytes(32'h08020000, 4);
        addBytes(32'h0, 1);
        pushExp(crcOfModel(), 2'd3, 1'b0);
        pushExp(len, 2'd3, 1'b0);
        pushExp(32'h49444154, 2'd3, 1'b0);
        model_bytes.delete();
        addBytes(32'h49444154, 4);
        if (len != 0) begin
            foreach (stim_q[k]) begin
                pushExp(stim_q[k].dat, stim_q[k].num, 1'b0);
                addBytes(stim_q[k].dat, int'(stim_q[k].num) + 1);
            end
        end
        pushExp(crcOfModel(), 2'd3, 1'b0);
        pushExp(32'h00000000, 2'd3, 1'b0);
        pushExp(32'h49454E44, 2'd3, 1'b0);
        pushExp(32'hAE426082, 2'd3, 1'b1);
    endtask

    // Runs one full stream from stim_q and checks the end-of-stream bookkeeping.
    task automatic applyStimulus(input string tname, input logic [31:0] w, input logic [31:0] h,
                                 input logic [31:0] len, input bit r_rdy, input bit r_zl, input bit glitch);
        int cyc;
        int sum;
        bit exp_err;
        exp_q.delete();
        buildExpected(w, h, len);
        sum = 0;
        foreach (stim_q[k]) sum += int'(stim_q[k].num) + 1;
        exp_err = (len != 0) && (32'(sum) != len);
        rand_rdy = r_rdy;
        rand_zl = r_zl;
        zl_q = stim_q;
        feed_en = 1'b1;
        done_cnt = 0;
        clr_cnt = 0;
        cur_len = len;
        crc_latency = $urandom_range(1, 4);
        @(negedge clk);
        start_i = 1'b1;
        w_i = w;
        h_i = h;
        idat_len_i = len;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checkOutput({tname, "_err_cleared"}, 64'(err_o), 64'(0));
        if (glitch) begin
            repeat (3) @(negedge clk);
            start_i = 1'b1;
            w_i = ~w;
            h_i = ~h;
            idat_len_i = len + 1;
            @(negedge clk);
            start_i = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (done_cnt == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: no done_o after %0d cycles", tname, cyc);
        end
        repeat (6) @(negedge clk);
        #1;
        checkOutput({tname, "_done_count"}, 64'(done_cnt), 64'(1));
        checkOutput({tname, "_err"}, 64'(err_o), 64'(exp_err));
        checkOutput({tname, "_clr_count"}, 64'(clr_cnt), 64'(2));
        checkOutput({tname, "_words_left"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        zl_q.delete();
    endtask

    initial begin
        rdy_i = 1'b0;
        forever begin
            @(negedge clk);
            rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Upstream zlib source: a word leaves the queue when valid and ready meet at the next edge.
    initial begin
        zl_val_i = 1'b0;
        zl_dat_i = '0;
        zl_num_i = '0;
        zl_lst_i = 1'b0;
        forever begin
            @(negedge clk);
            if (feed_en && zl_q.size() > 0 && !rst) begin
                zl_val_i = rand_zl ? 1'($urandom_range(0, 1)) : 1'b1;
                zl_dat_i = zl_q[0].dat;
                zl_num_i = zl_q[0].num;
                zl_lst_i = zl_q[0].lst;
            end else begin
                zl_val_i = 1'b0;
                zl_lst_i = 1'b0;
            end
            #1;
            if (zl_val_i && zl_rdy_o) void'(zl_q.pop_front());
        end
    end

    // Behavioural CRC-32 engine with a randomised result latency.
    initial begin
        logic [31:0] eng_crc;
        logic [31:0] eng_res;
        int pend;
        eng_crc = '0;
        eng_res = '0;
        pend = 0;
        crc_val_i = 1'b0;
        crc_dat_i = '0;
        forever begin
            @(negedge clk);
            crc_val_i = 1'b0;
            if (rst) begin
                eng_crc = '0;
                pend = 0;
            end else begin
                if (crc_clr_o) eng_crc = 32'hFFFFFFFF;
                if (crc_val_o) begin
                    for (int k = 0; k <= int'(crc_num_o); k++) eng_crc = crc_step(eng_crc, crc_dat_o[31-8*k -: 8]);
                    if (crc_lst_o) begin
                        eng_res = ~eng_crc;
                        pend = crc_latency;
                    end
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        crc_val_i = 1'b1;
                        crc_dat_i = eng_res;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    initial begin
        word_t e;
        logic pv;
        logic pr;
        logic [31:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) checkOutput("stall_hold", 64'({val_o, dat_o}), 64'({1'b1, pd}));
                if (done_o) done_cnt++;
                if (crc_clr_o) begin
                    checkOutput("clr_word", 64'(dat_o), 64'((clr_cnt == 0) ? 32'h0000000D : cur_len));
                    clr_cnt++;
                end
                if (val_o && rdy_i) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_word: got %h, expected no word", dat_o);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("stream_word", 64'({dat_o, num_o, lst_o}), 64'({e.dat, e.num, e.lst}));
                    end
                end
                pv = val_o;
                pr = rdy_i;
                pd = dat_o;
            end
        end
    end

    initial begin
        int cyc;
        logic [31:0] sum;
        int nw;
        rst = 1'b1;
        start_i = 1'b0;
        w_i = '0;
        h_i = '0;
        idat_len_i = '0;
        rand_rdy = 1'b0;
        rand_zl = 1'b0;
        feed_en = 1'b0;
        done_cnt = 0;
        clr_cnt = 0;
        cur_len = '0;
        crc_latency = 2;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_state", 64'({val_o, dat_o, num_o, lst_o, zl_rdy_o, crc_clr_o, crc_val_o,
                                        crc_num_o, crc_lst_o, done_o, err_o}), 64'(0));
        checkOutput("reset_crc_dat", 64'(crc_dat_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        stim_q.delete();
        stim_q.push_back('{32'h04090409, 2'd3, 1'b1});
        applyStimulus("basic", 32'd256, 32'd256, 32'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus("basic_stall", 32'd256, 32'd256, 32'd4, 1'b1, 1'b0, 1'b0);

        stim_q.delete();
        stim_q.push_back('{32'hAABBCCDD, 2'd3, 1'b0});
        stim_q.push_back('{32'hEEFF0000, 2'd1, 1'b1});
        applyStimulus("six_bytes", 32'd640, 32'd480, 32'd6, 1'b1, 1'b1, 1'b0);

        stim_q.delete();
        stim_q.push_back('{32'h11223344, 2'd3, 1'b1});
        applyStimulus("len_mismatch", 32'd17, 32'd9, 32'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus("after_mismatch", 32'd17, 32'd9, 32'd4, 1'b1, 1'b0, 1'b0);

        stim_q.delete();
        applyStimulus("zero_len", 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);

        stim_q.delete();
        stim_q.push_back('{32'h04090409, 2'd3, 1'b1});
        applyStimulus("start_glitch", 32'd256, 32'd256, 32'd4, 1'b0, 1'b0, 1'b1);

        // Reset while IDAT_DATA waits for zlib input, then a clean stream.
        exp_q.delete();
        buildExpected(32'd256, 32'd256, 32'd4);
        feed_en = 1'b0;
        rand_rdy = 1'b0;
        clr_cnt = 0;
        cur_len = 32'd4;
        @(negedge clk);
        start_i = 1'b1;
        w_i = 32'd256;
        h_i = 32'd256;
        idat_len_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (exp_q.size() > 5 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() > 5) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL reset_reach_idat: %0d words still pending, expected 5", exp_q.size());
        end
        repeat (3) @(negedge clk);
        #1;
        checkOutput("idat_zl_rdy", 64'(zl_rdy_o), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_outputs", 64'({val_o, dat_o, num_o, lst_o, zl_rdy_o, crc_clr_o, crc_val_o,
                                                 crc_num_o, crc_lst_o, done_o, err_o}), 64'(0));
        checkOutput("midrun_reset_crc_dat", 64'(crc_dat_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        zl_q.delete();
        applyStimulus("after_reset", 32'd256, 32'd256, 32'd4, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            stim_q.delete();
            nw = $urandom_range(1, 5);
            sum = '0;
            for (int k = 0; k < nw; k++) begin
                word_t t;
                t.dat = $urandom;
                t.num = (k == nw - 1) ? 2'($urandom_range(0, 3)) : 2'd3;
                t.lst = (k == nw - 1);
                sum = sum + 32'(t.num) + 32'd1;
                stim_q.push_back(t);
            end
            applyStimulus($sformatf("rand%0d", it), $urandom, $urandom, sum, 1'b1, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
